sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameters: MEM_WIDTH, 16, data width; ADDR_SIZE, 10, address width; RD_LAT, 2, SRAM clocks from sampled rd_en to valid dout (1 or 2); PARITY_CHECK, 1, enables parity compare.
REQ-002 SHALL have ports (clock and reset first):
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
a_req  in  1  requester A command request, held until a_gnt
a_we  in  1  A: 1 = write, 0 = read
a_addr  in  ADDR_SIZE  A address
a_wdata  in  MEM_WIDTH  A write data
a_gnt  out  1  A command accepted this cycle (combinational)
a_rvalid  out  1  A read data valid, one-cycle pulse
a_rdata  out  MEM_WIDTH  A read data
b_req / b_we / b_addr / b_wdata / b_gnt / b_rvalid / b_rdata  same as A, for requester B
sram_din  out  MEM_WIDTH  to SRAM din
sram_addr  out  ADDR_SIZE  to SRAM addr
sram_wr_en  out  1  to SRAM wr_en
sram_rd_en  out  1  to SRAM rd_en
sram_blk_select  out  1  to SRAM blk_select
sram_addr_en  out  1  to SRAM addr_en
sram_dout_en  out  1  to SRAM dout_en
sram_dout  in  MEM_WIDTH  from SRAM dout
sram_parity  in  1  from SRAM parity_out
parity_err  out  1  one-cycle pulse, parity mismatch on returned read
err_cnt  out  8  saturating count of parity mismatches
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 SHALL accept at most one command per cycle; x_gnt SHALL be high only when x_req is high; a_gnt and b_gnt never both high.
REQ-005 Only one requester: grant it. Both: grant the requester indicated by the priority pointer.
REQ-006 Priority pointer (1 bit, 0 = A) SHALL toggle to the non-granted requester after every grant; unchanged in cycles without a grant.
REQ-007 Grant in cycle N SHALL register the command so that in cycle N+1: sram_blk_select=1, sram_addr=addr, sram_wr_en=we, sram_rd_en=~we, sram_din=wdata (write) or held value (read).
REQ-008 Cycle with no grant SHALL be followed by sram_blk_select=0, sram_wr_en=0, sram_rd_en=0; sram_addr and sram_din hold previous values.
REQ-009 sram_addr_en and sram_dout_en SHALL be 1 in every cycle after reset deasserts.
REQ-010 A read granted in cycle N SHALL produce x_rvalid=1 for exactly cycle N+1+RD_LAT, with x_rdata=sram_dout in that cycle; owner carried by a tag/valid shift pipeline of depth RD_LAT+1.
REQ-011 Reads SHALL return in grant order; back-to-back reads every cycle SHALL be supported with no bubbles.
REQ-012 Writes SHALL produce no rvalid; a write granted after a read to the same address SHALL not affect that read's returned data (SRAM in-order).
REQ-013 x_rdata SHALL hold its last value when x_rvalid is 0.
REQ-014 With PARITY_CHECK=1, on each rvalid cycle parity_err SHALL equal (^sram_dout) != sram_parity (even parity); with PARITY_CHECK=0, parity_err is always 0.
REQ-015 err_cnt SHALL increment on each parity_err pulse and saturate at 255.

Reset
REQ-016 While rst=1 (sampled on clk): a_gnt=b_gnt=0; all sram_* outputs 0; a_rvalid=b_rvalid=0; a_rdata=b_rdata=0; parity_err=0; err_cnt=0; priority pointer=0 (A).
REQ-017 Reset mid-operation SHALL discard all in-flight reads; no rvalid for reads granted before reset.
REQ-018 First cycle after reset deasserts, arbitration SHALL be active (grant possible in that cycle).

Verification
REQ-019 A writes 0xBEEF to 0x005, then A reads 0x005 -> a_gnt in read cycle N, sram_rd_en=1 at N+1, a_rvalid=1 and a_rdata=0xBEEF at N+3 (RD_LAT=2).
REQ-020 a_req and b_req held high for 6 cycles after reset -> grants A,B,A,B,A,B; never both gnt in one cycle.
REQ-021 A reads 0x010 (data 0x1111) at N, B reads 0x020 (data 0x2222) at N+1 -> a_rvalid at N+3 with 0x1111, b_rvalid at N+4 with 0x2222, no cross-delivery.
REQ-022 Force sram_parity inverted on a read return -> parity_err=1 in rvalid cycle, err_cnt 0->1; 300 forced errors -> err_cnt=255.
REQ-023 Read granted at N, rst=1 at N+1 for one cycle -> no rvalid thereafter, all outputs 0 during reset, pointer=A.
REQ-024 Only b_req high, 200 random read/write commands vs. a reference memory model -> every B read returns model data, a_gnt never asserted.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester round-robin SRAM arbiter with ordered read return and parity check
module sram_arbiter #(
    parameter int MEM_WIDTH    = 16,
    parameter int ADDR_SIZE    = 10,
    parameter int RD_LAT       = 2,
    parameter int PARITY_CHECK = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [MEM_WIDTH-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [MEM_WIDTH-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [MEM_WIDTH-1:0] b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [MEM_WIDTH-1:0] b_rdata,
    output logic [MEM_WIDTH-1:0] sram_din,
    output logic [ADDR_SIZE-1:0] sram_addr,
    output logic                 sram_wr_en,
    output logic                 sram_rd_en,
    output logic                 sram_blk_select,
    output logic                 sram_addr_en,
    output logic                 sram_dout_en,
    input  logic [MEM_WIDTH-1:0] sram_dout,
    input  logic                 sram_parity,
    output logic                 parity_err,
    output logic [7:0]           err_cnt
);

    logic                 r_prio;
    logic                 r_blk, r_wr, r_rd, r_en;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [MEM_WIDTH-1:0] r_din;
    logic [RD_LAT:0]      r_vld;
    logic [RD_LAT:0]      r_own;
    logic [MEM_WIDTH-1:0] r_a_rdata, r_b_rdata;
    logic [7:0]           r_err_cnt;

    logic                 w_a_gnt, w_b_gnt, w_any_gnt, w_we, w_rd_gnt;
    logic [ADDR_SIZE-1:0] w_addr;
    logic [MEM_WIDTH-1:0] w_wdata;
    logic                 w_hit, w_a_hit, w_b_hit, w_par_err;

    // r_prio = 1 means B wins a tie
    always_comb begin
        w_a_gnt   = ~rst & a_req & (~b_req | ~r_prio);
        w_b_gnt   = ~rst & b_req & (~a_req | r_prio);
        w_any_gnt = w_a_gnt | w_b_gnt;
        w_we      = w_a_gnt ? a_we    : b_we;
        w_addr    = w_a_gnt ? a_addr  : b_addr;
        w_wdata   = w_a_gnt ? a_wdata : b_wdata;
        w_rd_gnt  = w_any_gnt & ~w_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
            r_blk  <= 1'b0;
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_en   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            if (w_a_gnt)
                r_prio <= 1'b1;
            else if (w_b_gnt)
                r_prio <= 1'b0;
            r_blk <= w_any_gnt;
            r_wr  <= w_any_gnt & w_we;
            r_rd  <= w_rd_gnt;
            r_en  <= 1'b1;
            if (w_any_gnt)
                r_addr <= w_addr;
            if (w_any_gnt && w_we)
                r_din <= w_wdata;
        end
    end

    // Owner tag (1 = B) travels with each read so returns are steered in grant order
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_own <= '0;
        end else begin
            r_vld <= {r_vld[RD_LAT-1:0], w_rd_gnt};
            r_own <= {r_own[RD_LAT-1:0], w_b_gnt};
        end
    end

    always_comb begin
        w_hit     = r_vld[RD_LAT];
        w_a_hit   = w_hit & ~r_own[RD_LAT];
        w_b_hit   = w_hit & r_own[RD_LAT];
        w_par_err = (PARITY_CHECK != 0) & w_hit & ((^sram_dout) != sram_parity);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
            r_err_cnt <= 8'd0;
        end else begin
            r_a_rdata <= a_rdata;
            r_b_rdata <= b_rdata;
            if (w_par_err && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign a_gnt           = w_a_gnt;
    assign b_gnt           = w_b_gnt;
    assign a_rvalid        = w_a_hit;
    assign b_rvalid        = w_b_hit;
    assign a_rdata         = w_a_hit ? sram_dout : r_a_rdata;
    assign b_rdata         = w_b_hit ? sram_dout : r_b_rdata;
    assign sram_din        = r_din;
    assign sram_addr       = r_addr;
    assign sram_wr_en      = r_wr;
    assign sram_rd_en      = r_rd;
    assign sram_blk_select = r_blk;
    assign sram_addr_en    = r_en;
    assign sram_dout_en    = r_en;
    assign parity_err      = w_par_err;
    assign err_cnt         = r_err_cnt;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed and random bench for sram_arbiter with SRAM model and read scoreboard
module tb_sram_arbiter;
    localparam int LAT = 2;

    logic        clk, rst;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [9:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid;
    logic [9:0]  b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic [15:0] sram_din, sram_dout;
    logic [9:0]  sram_addr;
    logic        sram_wr_en, sram_rd_en, sram_blk_select, sram_addr_en, sram_dout_en;
    logic        sram_parity, parity_err, force_bad;
    logic [7:0]  err_cnt;

    sram_arbiter #(.MEM_WIDTH(16), .ADDR_SIZE(10), .RD_LAT(LAT), .PARITY_CHECK(1)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_din(sram_din), .sram_addr(sram_addr), .sram_wr_en(sram_wr_en),
        .sram_rd_en(sram_rd_en), .sram_blk_select(sram_blk_select),
        .sram_addr_en(sram_addr_en), .sram_dout_en(sram_dout_en),
        .sram_dout(sram_dout), .sram_parity(sram_parity),
        .parity_err(parity_err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: rd_en sampled at an edge, data on dout LAT cycles later
    logic [15:0] mem [0:1023];
    logic [15:0] q1, q2;
    always @(posedge clk) begin
        if (sram_blk_select && sram_wr_en) mem[sram_addr] <= sram_din;
        if (sram_blk_select && sram_rd_en) q1 <= mem[sram_addr];
        q2 <= q1;
    end
    assign sram_dout   = q2;
    assign sram_parity = (^sram_dout) ^ force_bad;

    typedef struct {logic [15:0] data; int due; logic bad;} rd_t;
    rd_t         a_q[$], b_q[$];
    logic [15:0] ref_mem [0:1023];
    int          cyc, checks, errors, err_m;
    logic        prio_m, e_blk, e_wr, e_rd, e_en;
    logic [9:0]  e_addr;
    logic [15:0] e_din, a_last, b_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_cycle(input logic rs, input logic ar, input logic aw, input logic [9:0] aa,
                            input logic [15:0] ad, input logic br, input logic bw,
                            input logic [9:0] ba, input logic [15:0] bd, input logic bad);
        logic av, bv, ea, eb;
        rd_t  e;
        av = (a_q.size() > 0) && (a_q[0].due == cyc);
        bv = (b_q.size() > 0) && (b_q[0].due == cyc);
        force_bad = (av && a_q[0].bad) || (bv && b_q[0].bad);
        rst = rs; a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #2;
        check("a_rvalid", a_rvalid, av);
        check("b_rvalid", b_rvalid, bv);
        if (av) begin e = a_q.pop_front(); a_last = e.data; end
        if (bv) begin e = b_q.pop_front(); b_last = e.data; end
        check("a_rdata", a_rdata, a_last);
        check("b_rdata", b_rdata, b_last);
        check("parity_err", parity_err, force_bad);
        check("err_cnt", err_cnt, err_m);
        check("blk_select", sram_blk_select, e_blk);
        check("wr_en", sram_wr_en, e_wr);
        check("rd_en", sram_rd_en, e_rd);
        check("sram_addr", sram_addr, e_addr);
        check("sram_din", sram_din, e_din);
        check("addr_en", sram_addr_en, e_en);
        check("dout_en", sram_dout_en, e_en);
        ea = !rs && ar && (!br || !prio_m);
        eb = !rs && br && (!ar || prio_m);
        check("a_gnt", a_gnt, ea);
        check("b_gnt", b_gnt, eb);
        check("gnt_excl", a_gnt & b_gnt, 1'b0);
        if (rs) begin
            a_q.delete(); b_q.delete();
            prio_m = 0; e_blk = 0; e_wr = 0; e_rd = 0; e_en = 0;
            e_addr = '0; e_din = '0; a_last = '0; b_last = '0; err_m = 0;
        end else begin
            if (force_bad && err_m < 255) err_m++;
            e_en  = 1;
            e_blk = ea | eb;
            e_wr  = (ea && aw) || (eb && bw);
            e_rd  = (ea && !aw) || (eb && !bw);
            if (ea) begin e_addr = aa; if (aw) e_din = ad; prio_m = 1; end
            if (eb) begin e_addr = ba; if (bw) e_din = bd; prio_m = 0; end
            if (ea && !aw) a_q.push_back('{ref_mem[aa], cyc + 1 + LAT, bad});
            if (eb && !bw) b_q.push_back('{ref_mem[ba], cyc + 1 + LAT, bad});
            if (ea && aw) ref_mem[aa] = ad;
            if (eb && bw) ref_mem[ba] = bd;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic a_cmd(input logic we, input logic [9:0] ad, input logic [15:0] d, input logic bad);
        do_cycle(0, 1, we, ad, d, 0, 0, 0, 0, bad);
    endtask

    task automatic b_cmd(input logic we, input logic [9:0] ad, input logic [15:0] d, input logic bad);
        do_cycle(0, 0, 0, 0, 0, 1, we, ad, d, bad);
    endtask

    initial begin
        checks = 0; errors = 0; err_m = 0; cyc = 0; force_bad = 0;
        prio_m = 0; e_blk = 0; e_wr = 0; e_rd = 0; e_en = 0; e_addr = '0; e_din = '0;
        a_last = '0; b_last = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        rst = 1; a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        do_cycle(1, 1, 0, 10'h3, 16'h0, 1, 0, 10'h4, 16'h0, 0);

        // both requesting straight out of reset: A,B,A,B,A,B
        for (int i = 0; i < 6; i++) begin
            check("alt_seq_a", a_req & ~prio_m, (i % 2 == 0) ? 1'b1 : 1'b0);
            do_cycle(0, 1, 1, 10'h010, 16'h1111, 1, 1, 10'h020, 16'h2222, 0);
        end
        idle(2);

        a_cmd(1, 10'h005, 16'hBEEF, 0);
        a_cmd(0, 10'h005, 16'h0, 0);
        idle(4);
        check("beef_last", a_rdata, 16'hBEEF);

        a_cmd(0, 10'h010, 16'h0, 0);
        b_cmd(0, 10'h020, 16'h0, 0);
        idle(4);
        check("b_last_2222", b_rdata, 16'h2222);

        // back-to-back reads interleaved with a same-address write
        a_cmd(0, 10'h005, 16'h0, 0);
        a_cmd(1, 10'h005, 16'h1234, 0);
        a_cmd(0, 10'h005, 16'h0, 0);
        b_cmd(0, 10'h010, 16'h0, 0);
        a_cmd(0, 10'h020, 16'h0, 0);
        idle(4);

        a_cmd(0, 10'h010, 16'h0, 1);
        idle(4);
        check("err_cnt_one", err_cnt, 8'd1);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) a_cmd(0, 10'h020, 16'h0, 1);
            else            b_cmd(0, 10'h005, 16'h0, 1);
        end
        idle(4);
        check("err_cnt_sat", err_cnt, 8'd255);

        // reset one cycle after a read grant: that read never returns
        a_cmd(0, 10'h010, 16'h0, 0);
        do_cycle(1, 1, 0, 10'h010, 16'h0, 1, 0, 10'h020, 16'h0, 0);
        idle(5);

        for (int i = 0; i < 16; i++) b_cmd(1, 10'(i), 16'($urandom), 0);
        for (int i = 0; i < 200; i++)
            b_cmd(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 16'($urandom), 0);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
